// File: rtl/mod3_arbiter_ctrl.sv
// Two-requester round-robin front end for a serial MSB-first mod-3 residue engine.
// Captures the winning word and shifts it through a three-state residue FSM, one bit per clock.
module mod3_arbiter_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [1:0]       rem,
    output logic             div3
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [WIDTH-1:0] sh_q, sh_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [1:0]       res_q, res_d;
    logic [1:0]       rem_q, rem_d;
    logic [1:0]       gnt_q, gnt_d;
    logic             div3_q, div3_d;
    logic             id_q, id_d;
    logic             ptr_q, ptr_d;

    logic       any_req;
    logic       win1;
    logic       last_bit;
    logic [1:0] res_step;

    // ptr_q = 1 means requester 1 wins the next tie.
    always_comb begin
        any_req  = req0 | req1;
        win1     = req1 & (~req0 | ptr_q);
        last_bit = (cnt_q == CntW'(1));
    end

    // Residue step r' = (2r + bit) mod 3.
    always_comb begin
        res_step = 2'd0;
        unique case ({res_q, sh_q[WIDTH-1]})
            3'b00_0: res_step = 2'd0;
            3'b00_1: res_step = 2'd1;
            3'b01_0: res_step = 2'd2;
            3'b01_1: res_step = 2'd0;
            3'b10_0: res_step = 2'd1;
            3'b10_1: res_step = 2'd2;
            default: res_step = 2'd0;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    state_d = StShift;
                end
            end
            StShift: begin
                if (last_bit) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Datapath next-state
    always_comb begin
        sh_d   = sh_q;
        cnt_d  = cnt_q;
        res_d  = res_q;
        rem_d  = rem_q;
        div3_d = div3_q;
        id_d   = id_q;
        ptr_d  = ptr_q;
        gnt_d  = 2'b00;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    sh_d  = win1 ? data1 : data0;
                    res_d = 2'd0;
                    cnt_d = CntW'(WIDTH);
                    gnt_d = win1 ? 2'b10 : 2'b01;
                    id_d  = win1;
                    ptr_d = ~win1;
                end
            end
            StShift: begin
                sh_d  = sh_q << 1;
                res_d = res_step;
                cnt_d = cnt_q - CntW'(1);
                if (last_bit) begin
                    rem_d  = res_step;
                    div3_d = (res_step == 2'd0);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sh_q   <= '0;
            cnt_q  <= '0;
            res_q  <= 2'd0;
            rem_q  <= 2'd0;
            div3_q <= 1'b0;
            id_q   <= 1'b0;
            ptr_q  <= 1'b0;
            gnt_q  <= 2'b00;
        end else begin
            sh_q   <= sh_d;
            cnt_q  <= cnt_d;
            res_q  <= res_d;
            rem_q  <= rem_d;
            div3_q <= div3_d;
            id_q   <= id_d;
            ptr_q  <= ptr_d;
            gnt_q  <= gnt_d;
        end
    end

    // Outputs: decoded from registered state only
    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StDone);
        gnt     = gnt_q;
        done_id = id_q;
        rem     = rem_q;
        div3    = div3_q;
    end

endmodule

// File: tb/tb_mod3_arbiter_ctrl.sv
// Bench for mod3_arbiter_ctrl: timer/queue-level reference model checked every cycle, plus
// directed literal checks (single requests, tie alternation, full sweep, mid-op reset, WIDTH=1).
module tb_mod3_arbiter_ctrl;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         req0 = 1'b0, req1 = 1'b0;
    logic [W-1:0] data0 = '0, data1 = '0;
    logic [1:0]   gnt;
    logic         busy, done, done_id, div3;
    logic [1:0]   rem;

    logic       w_req0 = 1'b0, w_req1 = 1'b0;
    logic [0:0] w_data0 = '0, w_data1 = '0;
    logic [1:0] w_gnt;
    logic       w_busy, w_done, w_done_id, w_div3;
    logic [1:0] w_rem;

    mod3_arbiter_ctrl #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .data0(data0), .data1(data1),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id), .rem(rem), .div3(div3)
    );

    mod3_arbiter_ctrl #(.WIDTH(1)) u_dut_w1 (
        .clk(clk), .rst(rst), .req0(w_req0), .req1(w_req1), .data0(w_data0), .data1(w_data1),
        .gnt(w_gnt), .busy(w_busy), .done(w_done), .done_id(w_done_id), .rem(w_rem),
        .div3(w_div3)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int tcyc  = 0;

    always @(posedge clk) tcyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a busy timer of WIDTH+1 cycles per accepted word, result = word % 3.
    int         m_t    = 0;
    int         m_win  = 0;
    int         m_val  = 0;
    int         m_last = 1;
    logic [1:0] m_rem  = 2'd0;
    logic       m_div  = 1'b0;
    logic       m_id   = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_t = 0; m_last = 1; m_rem = 2'd0; m_div = 1'b0; m_id = 1'b0;
        end else if (m_t == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_win = 1 - m_last;
                else              m_win = req1 ? 1 : 0;
                m_val  = int'(m_win == 1 ? data1 : data0) % 3;
                m_last = m_win;
                m_id   = (m_win == 1);
                m_t    = W + 1;
            end
        end else begin
            m_t--;
            if (m_t == 1) begin
                m_rem = 2'(m_val);
                m_div = (m_val == 0);
            end
        end
    end

    always @(negedge clk) begin
        chk("gnt", gnt, (m_t == W + 1) ? (m_id ? 2 : 1) : 0);
        chk("busy", busy, m_t != 0);
        chk("done", done, m_t == 1);
        chk("rem", rem, m_rem);
        chk("div3", div3, m_div);
        chk("done_id", done_id, m_id);
    end

    task automatic run_op(input int r, input logic [W-1:0] d, output int glat, output int dlat,
                          output logic [1:0] g_at, output int bcnt);
        @(negedge clk);
        if (r == 0) begin req0 = 1'b1; data0 = d; end
        else        begin req1 = 1'b1; data1 = d; end
        glat = -1; dlat = -1; g_at = 2'b00; bcnt = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (busy) bcnt++;
            if (glat < 0 && gnt != 2'b00) begin
                glat = c; g_at = gnt;
                if (r == 0) req0 = 1'b0; else req1 = 1'b0;
            end
            if (done) begin dlat = c; break; end
        end
        req0 = 1'b0; req1 = 1'b0;
        if (dlat < 0) chk("op_timeout", 0, 1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int gl, dl, bc, gt_prev, wl;
        logic [1:0] g;
        bit seen;

        // Reset values
        @(negedge clk);
        chk("rst_gnt", gnt, 0); chk("rst_busy", busy, 0); chk("rst_done", done, 0);
        chk("rst_rem", rem, 0); chk("rst_div3", div3, 0); chk("rst_id", done_id, 0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Single requests
        run_op(0, 8'd9, gl, dl, g, bc);
        chk("t1_gnt_lat", gl, 1); chk("t1_gnt", g, 2'b01); chk("t1_done_lat", dl, 9);
        chk("t1_rem", rem, 0); chk("t1_div3", div3, 1); chk("t1_id", done_id, 0);
        run_op(1, 8'd200, gl, dl, g, bc);
        chk("t2_gnt", g, 2'b10); chk("t2_rem", rem, 2); chk("t2_div3", div3, 0);
        chk("t2_id", done_id, 1); chk("t2_busy_cycles", bc, 9);

        // Sustained tie: alternating grants spaced WIDTH+2 apart
        do_reset();
        @(negedge clk);
        req0 = 1'b1; req1 = 1'b1; data0 = 8'd7; data1 = 8'd255;
        gt_prev = 0;
        for (int k = 0; k < 4; k++) begin
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (gnt != 2'b00) begin seen = 1; break; end
            end
            chk("tie_gnt_seen", seen, 1);
            chk("tie_gnt", gnt, (k % 2) ? 2 : 1);
            if (k > 0) chk("tie_spacing", tcyc - gt_prev, W + 2);
            gt_prev = tcyc;
            seen = 0;
            for (int c = 0; c < 30; c++) begin
                @(negedge clk);
                if (done) begin seen = 1; break; end
            end
            chk("tie_done_seen", seen, 1);
            chk("tie_rem", rem, (k % 2) ? 0 : 1);
            chk("tie_div3", div3, (k % 2) ? 1 : 0);
            chk("tie_id", done_id, k % 2);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);

        // Edge words
        run_op(0, 8'd0, gl, dl, g, bc);
        chk("zero_rem", rem, 0); chk("zero_div3", div3, 1);
        run_op(0, 8'hFF, gl, dl, g, bc);
        chk("ff_rem", rem, 0); chk("ff_div3", div3, 1);

        // Full sweep of requester 0
        for (int v = 0; v < 256; v++) begin
            run_op(0, 8'(v), gl, dl, g, bc);
            chk("sweep_rem", rem, v % 3);
            chk("sweep_div3", div3, (v % 3) == 0);
            chk("sweep_rem_valid", rem != 2'b11, 1);
        end

        // Reset in the 4th SHIFT cycle, asynchronously between edges
        run_op(1, 8'd200, gl, dl, g, bc);
        @(negedge clk);
        req0 = 1'b1; data0 = 8'd85;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (gnt != 2'b00) begin seen = 1; break; end
        end
        chk("mr_gnt_seen", seen, 1);
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("mr_gnt", gnt, 0); chk("mr_busy", busy, 0); chk("mr_done", done, 0);
        chk("mr_rem", rem, 0); chk("mr_div3", div3, 0); chk("mr_id", done_id, 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        wl = -1;
        for (int c = 1; c < 30; c++) begin
            @(negedge clk);
            if (gnt != 2'b00 && wl < 0) begin wl = c; req0 = 1'b0; end
            if (done) break;
        end
        chk("mr_regrant_lat", wl, 1);
        chk("mr_after_done", done, 1); chk("mr_after_rem", rem, 1); chk("mr_after_id", done_id, 0);
        req0 = 1'b0;
        repeat (2) @(negedge clk);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            req0  = (gnt[0] == 1'b1) ? 1'b0 : ($urandom_range(0, 3) == 0);
            req1  = (gnt[1] == 1'b1) ? 1'b0 : ($urandom_range(0, 3) == 0);
            data0 = 8'($urandom);
            data1 = 8'($urandom);
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (12) @(negedge clk);

        // WIDTH=1 instance: gnt and done in consecutive cycles
        for (int v = 0; v < 2; v++) begin
            @(negedge clk);
            w_req0 = 1'b1; w_data0 = 1'(v);
            gl = -1; dl = -1;
            for (int c = 1; c < 10; c++) begin
                @(negedge clk);
                if (gl < 0 && w_gnt != 2'b00) begin gl = c; g = w_gnt; w_req0 = 1'b0; end
                if (w_done) begin dl = c; break; end
            end
            w_req0 = 1'b0;
            chk("w1_gnt_lat", gl, 1); chk("w1_gnt", g, 2'b01); chk("w1_done_lat", dl, 2);
            chk("w1_rem", w_rem, v); chk("w1_div3", w_div3, v == 0);
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
